// File: rtl/sd_pkg.sv
// Shared SD host constants and types.
// Divider defaults are consumed by the clock generator and the controller top.
package sd_pkg;

    localparam int SD_DIV_W = 8;

    localparam logic [SD_DIV_W-1:0] SD_DIV_INIT = 8'd62;
    localparam logic [SD_DIV_W-1:0] SD_DIV_FAST = 8'd0;

    typedef enum logic {
        SD_CLK_PARKED = 1'b0,
        SD_CLK_ACTIVE = 1'b1
    } sd_clk_state_t;

endpackage

// File: rtl/sd_clk_gen.sv
// SD card clock generator: programmable divider with edge strobes,
// glitch-free start/stop and divider updates only at falling edges.
module sd_clk_gen
    import sd_pkg::*;
#(
    parameter int              DIV_W       = SD_DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = SD_DIV_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             sd_clk,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             running
);

    sd_clk_state_t    state_q;
    sd_clk_state_t    state_d;
    logic             clk_q;
    logic             clk_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             terminal;

    assign terminal = (cnt_q == div_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SD_CLK_PARKED;
            clk_q   <= 1'b0;
            cnt_q   <= '0;
            div_q   <= DEFAULT_DIV;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clk_d   = clk_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            SD_CLK_PARKED: begin
                clk_d = 1'b0;
                cnt_d = '0;
                div_d = div;
                if (en) begin
                    state_d = SD_CLK_ACTIVE;
                end
            end
            SD_CLK_ACTIVE: begin
                if (!terminal) begin
                    // Compare precedes increment, so cnt never wraps.
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (clk_q) begin
                        clk_d  = 1'b0;
                        fall_d = 1'b1;
                        div_d  = div;
                        if (!en) begin
                            state_d = SD_CLK_PARKED;
                        end
                    end else if (en) begin
                        clk_d  = 1'b1;
                        rise_d = 1'b1;
                    end else begin
                        // Low phase finished with en gone: park without rising.
                        state_d = SD_CLK_PARKED;
                        div_d   = div;
                    end
                end
            end
            default: begin
                state_d = SD_CLK_PARKED;
            end
        endcase
    end

    assign sd_clk   = clk_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
    assign running  = (state_q == SD_CLK_ACTIVE);

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed bench for sd_clk_gen: start-up latency, periods, divider
// changes, stop behaviour and reset abort.
module tb_sd_clk_gen;
    import sd_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic       sd_clk;
    logic       rise_stb;
    logic       fall_stb;
    logic       running;

    int checks = 0;
    int errors = 0;
    int n;
    logic bad;

    sd_clk_gen #(
        .DIV_W      (SD_DIV_W),
        .DEFAULT_DIV(SD_DIV_INIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div     (div),
        .sd_clk  (sd_clk),
        .rise_stb(rise_stb),
        .fall_stb(fall_stb),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until the requested strobe appears; bounded.
    task automatic wait_stb(input bit want_rise, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
            if (rise_stb && fall_stb) begin
                check("both_stb", 1, 0);
            end
        end while (!(want_rise ? rise_stb : fall_stb) && cnt < 600);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        div = 8'd3;

        // Reset state and basic div=3 operation
        do_reset();
        check("rst_sd_clk", sd_clk, 0);
        check("rst_rise", rise_stb, 0);
        check("rst_fall", fall_stb, 0);
        check("rst_running", running, 0);
        en = 1'b1;
        tick();
        check("d3_running", running, 1);
        check("d3_low_start", sd_clk, 0);
        wait_stb(1'b1, n);
        check("d3_first_rise", n, 4);
        check("d3_rise_lvl", sd_clk, 1);
        wait_stb(1'b0, n);
        check("d3_high", n, 4);
        check("d3_fall_lvl", sd_clk, 0);
        wait_stb(1'b1, n);
        check("d3_low", n, 4);

        // div=0: strobes alternate every cycle
        do_reset();
        div = 8'd0;
        en  = 1'b1;
        tick();
        wait_stb(1'b1, n);
        check("d0_first_rise", n, 1);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fall_stb !== (i % 2 == 0)) bad = 1'b1;
            if (rise_stb !== (i % 2 == 1)) bad = 1'b1;
            if (sd_clk !== (i % 2 == 1)) bad = 1'b1;
        end
        check("d0_alternate", bad, 0);

        // div 3 -> 1 mid high phase
        do_reset();
        div = 8'd3;
        en  = 1'b1;
        tick();
        wait_stb(1'b1, n);
        tick();
        div = 8'd1;
        wait_stb(1'b0, n);
        check("chg_high_rest", n, 3);
        wait_stb(1'b1, n);
        check("chg_low", n, 2);
        wait_stb(1'b0, n);
        check("chg_high", n, 2);

        // en dropped one cycle into a div=5 high phase
        do_reset();
        div = 8'd5;
        en  = 1'b1;
        tick();
        wait_stb(1'b1, n);
        check("d5_first_rise", n, 6);
        en = 1'b0;
        wait_stb(1'b0, n);
        check("stop_high_len", n, 6);
        check("stop_running", running, 0);
        check("stop_sd_clk", sd_clk, 0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sd_clk || rise_stb || fall_stb || running) bad = 1'b1;
        end
        check("parked_quiet", bad, 0);

        // Re-enable from park at div=2
        div = 8'd2;
        en  = 1'b1;
        tick();
        check("reen_running", running, 1);
        wait_stb(1'b1, n);
        check("reen_first_rise", n, 3);

        // en dropped at start of low phase: finish low, no rise, park
        wait_stb(1'b0, n);
        en = 1'b0;
        tick();
        tick();
        check("lowstop_mid_run", running, 1);
        tick();
        check("lowstop_parked", running, 0);
        check("lowstop_no_rise", rise_stb | sd_clk, 0);

        // rst during a div=255 high phase, then fresh start
        do_reset();
        div = 8'd255;
        en  = 1'b1;
        tick();
        wait_stb(1'b1, n);
        check("d255_first_rise", n, 256);
        for (int i = 0; i < 10; i++) tick();
        check("d255_still_high", sd_clk, 1);
        rst = 1'b1;
        tick();
        check("abort_sd_clk", sd_clk, 0);
        check("abort_stb", rise_stb | fall_stb, 0);
        check("abort_running", running, 0);
        rst = 1'b0;
        div = SD_DIV_INIT;
        tick();
        check("fresh_running", running, 1);
        wait_stb(1'b1, n);
        check("fresh_first_rise", n, 63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
